io_timer_intc: RTL

- Memory-mapped responder on the CPU data bus (WE/RE/address/databus) for the interrupt registers IF (FF0F) and IE (FFFF) and the timer registers DIV, TIMA, TMA and TAC (FF04-FF07).
- Latches interrupt requests from the peripherals and from its own timer.
- Presents pending flags and the enable mask to the CPU's interrupt inputs.
- Consumes the CPU's int_clear acknowledge.

---
 rtl/io_timer_intc_if.sv | 7 +
 rtl/io_timer_intc.sv | 75 +++++++
 2 files changed

// File: rtl/io_timer_intc_if.sv
// io_timer_intc_if: CPU bus address and read/write strobes
interface io_timer_intc_if;
  logic [15:0] address;
  logic RE, WE;
  modport master (output address, RE, WE);
  modport slave (input address, RE, WE);
endinterface

// File: rtl/io_timer_intc.sv
// io_timer_intc: interrupt flag/enable registers and DIV/TIMA/TMA/TAC timer on the CPU bus
module io_timer_intc #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF,
  parameter logic [15:0] TIMER_BASE = 16'hFF04
) (
  input logic clk,
  input logic rst,
  io_timer_intc_if.slave bus,
  inout wire [7:0] databus,
  input logic vblank_req,
  input logic lcdc_req,
  input logic serial_req,
  input logic joypad_req,
  input logic int_clear,
  output logic vblank_int,
  output logic lcdc_int,
  output logic timer_int,
  output logic serial_int,
  output logic joypad_int,
  output logic [7:0] int_en
);
  logic [15:0] counter;
  logic [7:0] tima, tma, ie, rdata;
  logic [4:0] flags, flags_n, pend, clr;
  logic [3:0] req, req_q, rise;
  logic [2:0] tac;
  logic t_q, sel, t, tick, ovf, hit;
  logic at_if, at_ie, at_div, at_tima, at_tma, at_tac;
  assign at_if = bus.address == IF_ADDR;
  assign at_ie = bus.address == IE_ADDR;
  assign at_div = bus.address == TIMER_BASE;
  assign at_tima = bus.address == TIMER_BASE + 16'd1;
  assign at_tma = bus.address == TIMER_BASE + 16'd2;
  assign at_tac = bus.address == TIMER_BASE + 16'd3;
  assign hit = at_if | at_ie | at_div | at_tima | at_tma | at_tac;
  assign req = {joypad_req, serial_req, lcdc_req, vblank_req};
  assign rise = req & ~req_q;
  assign sel = tac[1] ? (tac[0] ? counter[7] : counter[5]) : (tac[0] ? counter[3] : counter[9]);
  assign t = tac[2] & sel;
  assign tick = t_q & ~t;
  assign ovf = tick & (tima == 8'hFF) & ~(bus.WE & at_tima);
  // lowest set bit of the pending-and-enabled set is the one acknowledged
  assign pend = flags & ie[4:0];
  assign clr = int_clear ? pend & (~pend + 5'd1) : 5'd0;
  assign flags_n = (((bus.WE & at_if) ? databus[4:0] : flags) & ~clr) | {rise[3:2], ovf, rise[1:0]};
  always_comb begin
    rdata = at_if ? {3'b111, flags} : at_ie ? ie : at_div ? counter[15:8] :
            at_tima ? tima : at_tma ? tma : {5'b11111, tac};
  end
  assign databus = (bus.RE && !bus.WE && hit) ? rdata : 8'hzz;
  assign {joypad_int, serial_int, timer_int, lcdc_int, vblank_int} = flags;
  assign int_en = ie;
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      tima <= '0;
      tma <= '0;
      tac <= '0;
      ie <= '0;
      flags <= '0;
      req_q <= '0;
      t_q <= 1'b0;
    end else begin
      counter <= (bus.WE && at_div) ? 16'd0 : counter + 16'd1;
      t_q <= t;
      req_q <= req;
      flags <= flags_n;
      if (bus.WE && at_ie) ie <= databus;
      if (bus.WE && at_tma) tma <= databus;
      if (bus.WE && at_tac) tac <= databus[2:0];
      tima <= (bus.WE && at_tima) ? databus : tick ? ((tima == 8'hFF) ? tma : tima + 8'd1) : tima;
    end
  end
endmodule
